// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if.sv
//
// Bus bundles for the memory access unit.
//
// mau_req_if : controller side. The controller (master) presents one
//              load/store/fetch request at a time and waits for a one-cycle
//              completion pulse from the unit (slave).
//   req_valid, req_write, req_addr, req_funct3, req_wdata : master -> slave
//   req_ready, rsp_valid, rsp_rdata, misaligned, bus_err   : slave -> master
//
// mau_mem_if : memory side. The unit (master) issues req/gnt/rvalid
//              transactions to a variable-latency unified memory (slave).
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata : master -> slave
//   mem_gnt, mem_rvalid, mem_rdata               : slave -> master
// ---------------------------------------------------------------------------

interface mau_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              misaligned;
  logic              bus_err;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, misaligned, bus_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, misaligned, bus_err
  );
endinterface

interface mau_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit.sv
//
// Load/store and fetch port between the multicycle controller/datapath and
// a unified instruction/data memory with variable latency. One request is
// handled at a time: it is checked for legality, issued on the memory
// req/gnt/rvalid handshake with byte enables and lane-replicated store data,
// and load data is extracted and sign/zero-extended on return. Misaligned or
// illegal accesses and accesses that exceed TIMEOUT_CYCLES are reported with
// the one-cycle completion pulse.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active low
//   req_bus : controller side (mau_req_if.slave)
//   mem_bus : memory side (mau_mem_if.master)
// ---------------------------------------------------------------------------

module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input logic       clk,
  input logic       rst,
  mau_req_if.slave  req_bus,
  mau_mem_if.master mem_bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_e            state_q,      state_d;
  logic [15:0]       cnt_q,        cnt_d;
  logic [1:0]        addr_lo_q,    addr_lo_d;
  logic [2:0]        funct3_q,     funct3_d;
  logic              write_q,      write_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic [31:0]       rsp_rdata_q,  rsp_rdata_d;
  logic              misaligned_q, misaligned_d;
  logic              bus_err_q,    bus_err_d;
  logic              mem_req_q,    mem_req_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [3:0]        mem_be_q,     mem_be_d;
  logic [31:0]       mem_wdata_q,  mem_wdata_d;

  logic              req_illegal;
  logic [3:0]        req_be;
  logic [31:0]       req_lane_wdata;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_data;
  logic [15:0]       cnt_inc;
  logic              timeout_hit;

  // Legality of the incoming request. Stores only know b/h/w; unsigned
  // variants and the reserved codes are rejected before touching memory.
  always_comb begin
    req_illegal = 1'b0;
    case (req_bus.req_funct3)
      3'b000:         req_illegal = 1'b0;
      3'b001:         req_illegal = req_bus.req_addr[0];
      3'b010:         req_illegal = |req_bus.req_addr[1:0];
      3'b100:         req_illegal = req_bus.req_write;
      3'b101:         req_illegal = req_bus.req_addr[0] | req_bus.req_write;
      default:        req_illegal = 1'b1;
    endcase
  end

  // Byte enables and lane replication. Replicating the store data across
  // all lanes lets the memory pick whichever lanes the enables select.
  // Loads always read the full word.
  always_comb begin
    req_be         = 4'b1111;
    req_lane_wdata = req_bus.req_wdata;
    if (req_bus.req_write) begin
      case (req_bus.req_funct3[1:0])
        2'b00: begin
          req_be         = 4'b0001 << req_bus.req_addr[1:0];
          req_lane_wdata = {4{req_bus.req_wdata[7:0]}};
        end
        2'b01: begin
          req_be         = req_bus.req_addr[1] ? 4'b1100 : 4'b0011;
          req_lane_wdata = {2{req_bus.req_wdata[15:0]}};
        end
        default: begin
          req_be         = 4'b1111;
          req_lane_wdata = req_bus.req_wdata;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the latched low address
  // bits and size code.
  always_comb begin
    load_byte = 8'h00;
    case (addr_lo_q)
      2'd0:    load_byte = mem_bus.mem_rdata[7:0];
      2'd1:    load_byte = mem_bus.mem_rdata[15:8];
      2'd2:    load_byte = mem_bus.mem_rdata[23:16];
      default: load_byte = mem_bus.mem_rdata[31:24];
    endcase
    load_half = addr_lo_q[1] ? mem_bus.mem_rdata[31:16] : mem_bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = mem_bus.mem_rdata;
    endcase
  end

  // The access is aborted when the cycle now ending brings the counter up
  // to the limit, so the request stays on the bus for exactly
  // TIMEOUT_CYCLES cycles.
  assign cnt_inc     = cnt_q + 16'd1;
  assign timeout_hit = (cnt_inc == TIMEOUT_LIM);

  // Next-state and registered-output logic. Response flags default to zero
  // so they are only high in the RESP cycle; the bus outputs hold their
  // values unless a state change updates them.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    write_d      = write_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_bus.req_valid) begin
          addr_lo_d = req_bus.req_addr[1:0];
          funct3_d  = req_bus.req_funct3;
          write_d   = req_bus.req_write;
          if (req_illegal) begin
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            misaligned_d = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            cnt_d       = 16'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_bus.req_write;
            mem_addr_d  = {req_bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_lane_wdata;
          end
        end
      end

      // A grant in the final allowed cycle still times out: only a data
      // return can complete the access.
      ST_ISSUE: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          bus_err_d   = 1'b1;
          mem_req_d   = 1'b0;
        end else if (mem_bus.mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end
      end

      // Completion takes priority over a timeout landing in the same cycle.
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_bus.mem_rvalid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          if (!write_q) begin
            rsp_rdata_d = load_data;
          end
        end else if (timeout_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          bus_err_d   = 1'b1;
          mem_req_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      addr_lo_q    <= 2'd0;
      funct3_q     <= 3'd0;
      write_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      write_q      <= write_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_bus.req_ready  = (state_q == ST_IDLE);
  assign req_bus.rsp_valid  = rsp_valid_q;
  assign req_bus.rsp_rdata  = rsp_rdata_q;
  assign req_bus.misaligned = misaligned_q;
  assign req_bus.bus_err    = bus_err_q;

  assign mem_bus.mem_req    = mem_req_q;
  assign mem_bus.mem_we     = mem_we_q;
  assign mem_bus.mem_addr   = mem_addr_q;
  assign mem_bus.mem_be     = mem_be_q;
  assign mem_bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit.sv
//
// Directed bench for mem_access_unit. The memory side is driven cycle by
// cycle from the stimulus sequence; every expected value is hand-computed.
// The unit is built with an 8-cycle timeout so the abort path is short.
// ---------------------------------------------------------------------------

module tb_mem_access_unit;

  logic clk;
  logic rst;

  int vec_count   = 0;
  int miscompares = 0;
  int pulse_count;

  mau_req_if #(.ADDR_W(32)) req_if ();
  mau_mem_if #(.ADDR_W(32)) mem_if ();

  mem_access_unit #(
    .TIMEOUT_CYCLES(8),
    .ADDR_W        (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_bus(req_if),
    .mem_bus(mem_if)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge; all sampling and
  // driving happen at this point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on the controller side.
  task automatic applyStimulus(input logic valid, input logic wr,
                               input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wdata);
    req_if.req_valid  = valid;
    req_if.req_write  = wr;
    req_if.req_addr   = addr;
    req_if.req_funct3 = f3;
    req_if.req_wdata  = wdata;
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Simple one-word load with immediate grant and data one cycle later;
  // checks the three-cycle latency and the extracted result.
  task automatic loadImmediate(input string tag, input logic [31:0] addr,
                               input logic [2:0] f3, input logic [31:0] rdata,
                               input logic [31:0] exp_addr,
                               input logic [31:0] exp_rdata);
    applyStimulus(1'b1, 1'b0, addr, f3, 32'h0);
    tick();
    req_if.req_valid = 1'b0;
    checkOutput({tag, "_req"}, 32'(mem_if.mem_req), 32'd1);
    checkOutput({tag, "_addr"}, mem_if.mem_addr, exp_addr);
    checkOutput({tag, "_be"}, 32'(mem_if.mem_be), 32'hF);
    checkOutput({tag, "_we"}, 32'(mem_if.mem_we), 32'd0);
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    checkOutput({tag, "_req_drop"}, 32'(mem_if.mem_req), 32'd0);
    checkOutput({tag, "_no_rsp"}, 32'(req_if.rsp_valid), 32'd0);
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = rdata;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checkOutput({tag, "_rsp"}, 32'(req_if.rsp_valid), 32'd1);
    checkOutput({tag, "_rdata"}, req_if.rsp_rdata, exp_rdata);
    checkOutput({tag, "_mis"}, 32'(req_if.misaligned), 32'd0);
    checkOutput({tag, "_berr"}, 32'(req_if.bus_err), 32'd0);
    tick();
    checkOutput({tag, "_rsp_end"}, 32'(req_if.rsp_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(req_if.req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 32'h0;

    // Reset state
    tick();
    checkOutput("rst_ready", 32'(req_if.req_ready), 32'd1);
    checkOutput("rst_rsp", 32'(req_if.rsp_valid), 32'd0);
    checkOutput("rst_rdata", req_if.rsp_rdata, 32'h0);
    checkOutput("rst_req", 32'(mem_if.mem_req), 32'd0);
    checkOutput("rst_addr", mem_if.mem_addr, 32'h0);
    checkOutput("rst_be", 32'(mem_if.mem_be), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // lb / lbu at 0x103: byte lane 3 of 0x80FF1234 is 0x80
    loadImmediate("lb", 32'h103, 3'b000, 32'h80FF_1234, 32'h100, 32'hFFFF_FF80);
    loadImmediate("lbu", 32'h103, 3'b100, 32'h80FF_1234, 32'h100, 32'h0000_0080);

    // sh at 0x206 with grant on the third issue cycle; a stray rvalid while
    // issuing must be ignored
    applyStimulus(1'b1, 1'b1, 32'h206, 3'b001, 32'h0000_BEEF);
    tick();
    req_if.req_valid = 1'b0;
    checkOutput("sh_req1", 32'(mem_if.mem_req), 32'd1);
    checkOutput("sh_addr", mem_if.mem_addr, 32'h204);
    checkOutput("sh_be", 32'(mem_if.mem_be), 32'hC);
    checkOutput("sh_wdata", mem_if.mem_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_we", 32'(mem_if.mem_we), 32'd1);
    mem_if.mem_rvalid = 1'b1;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checkOutput("sh_req2", 32'(mem_if.mem_req), 32'd1);
    checkOutput("sh_issue_rv", 32'(req_if.rsp_valid), 32'd0);
    tick();
    checkOutput("sh_req3", 32'(mem_if.mem_req), 32'd1);
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    checkOutput("sh_req_drop", 32'(mem_if.mem_req), 32'd0);
    checkOutput("sh_wait_rsp", 32'(req_if.rsp_valid), 32'd0);
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'hDEAD_DEAD;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checkOutput("sh_rsp", 32'(req_if.rsp_valid), 32'd1);
    checkOutput("sh_rdata_keep", req_if.rsp_rdata, 32'h0000_0080);
    checkOutput("sh_berr", 32'(req_if.bus_err), 32'd0);
    tick();

    // sb at 0x101: lane 1, data replicated
    applyStimulus(1'b1, 1'b1, 32'h101, 3'b000, 32'h1234_56A5);
    tick();
    req_if.req_valid = 1'b0;
    checkOutput("sb_be", 32'(mem_if.mem_be), 32'h2);
    checkOutput("sb_wdata", mem_if.mem_wdata, 32'hA5A5_A5A5);
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b1;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checkOutput("sb_rsp", 32'(req_if.rsp_valid), 32'd1);
    tick();

    // Misaligned lw and reserved funct3: response one cycle after accept
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h002, (k == 0) ? 3'b010 : 3'b011, 32'h0);
      tick();
      req_if.req_valid = 1'b0;
      checkOutput("mis_rsp", 32'(req_if.rsp_valid), 32'd1);
      checkOutput("mis_flag", 32'(req_if.misaligned), 32'd1);
      checkOutput("mis_berr", 32'(req_if.bus_err), 32'd0);
      checkOutput("mis_no_req", 32'(mem_if.mem_req), 32'd0);
      checkOutput("mis_rdata_keep", req_if.rsp_rdata, 32'h0000_0080);
      tick();
      checkOutput("mis_clear", 32'(req_if.misaligned), 32'd0);
      checkOutput("mis_ready", 32'(req_if.req_ready), 32'd1);
    end

    // lbu-as-store is illegal
    applyStimulus(1'b1, 1'b1, 32'h000, 3'b100, 32'h0);
    tick();
    req_if.req_valid = 1'b0;
    checkOutput("sbu_mis", 32'(req_if.misaligned), 32'd1);
    tick();

    // Timeout: no grant, request held for 8 cycles then bus_err
    applyStimulus(1'b1, 1'b0, 32'h010, 3'b010, 32'h0);
    tick();
    req_if.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("to_req_held", 32'(mem_if.mem_req), 32'd1);
      checkOutput("to_no_rsp", 32'(req_if.rsp_valid), 32'd0);
      tick();
    end
    checkOutput("to_req_drop", 32'(mem_if.mem_req), 32'd0);
    checkOutput("to_rsp", 32'(req_if.rsp_valid), 32'd1);
    checkOutput("to_berr", 32'(req_if.bus_err), 32'd1);
    checkOutput("to_mis", 32'(req_if.misaligned), 32'd0);
    tick();
    checkOutput("to_berr_clear", 32'(req_if.bus_err), 32'd0);
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'h5555_5555;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checkOutput("to_late_rv", 32'(req_if.rsp_valid), 32'd0);
    tick();
    checkOutput("to_late_rv2", 32'(req_if.rsp_valid), 32'd0);
    checkOutput("to_rdata_keep", req_if.rsp_rdata, 32'h0000_0080);

    // Reset while waiting for data
    applyStimulus(1'b1, 1'b0, 32'h040, 3'b010, 32'h0);
    tick();
    req_if.req_valid = 1'b0;
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    checkOutput("mr_in_wait", 32'(req_if.req_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mr_ready", 32'(req_if.req_ready), 32'd1);
    checkOutput("mr_addr", mem_if.mem_addr, 32'h0);
    checkOutput("mr_be", 32'(mem_if.mem_be), 32'h0);
    checkOutput("mr_rdata", req_if.rsp_rdata, 32'h0);
    checkOutput("mr_req", 32'(mem_if.mem_req), 32'd0);
    tick();
    rst = 1'b1;
    mem_if.mem_rvalid = 1'b1;
    tick();
    mem_if.mem_rvalid = 1'b0;
    checkOutput("mr_no_rsp", 32'(req_if.rsp_valid), 32'd0);
    loadImmediate("lw_after_rst", 32'h000, 3'b010, 32'h1234_5678, 32'h0, 32'h1234_5678);

    // Back-to-back with req_valid held: lh then lhu at 0x002
    pulse_count = 0;
    applyStimulus(1'b1, 1'b0, 32'h002, 3'b001, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h002, 3'b101, 32'h0);
    checkOutput("b2b_busy", 32'(req_if.req_ready), 32'd0);
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'h9ABC_1234;
    tick();
    mem_if.mem_rvalid = 1'b0;
    pulse_count += int'(req_if.rsp_valid);
    checkOutput("b2b_rdata1", req_if.rsp_rdata, 32'hFFFF_9ABC);
    checkOutput("b2b_resp_busy", 32'(req_if.req_ready), 32'd0);
    tick();
    pulse_count += int'(req_if.rsp_valid);
    checkOutput("b2b_idle", 32'(req_if.req_ready), 32'd1);
    tick();
    req_if.req_valid = 1'b0;
    pulse_count += int'(req_if.rsp_valid);
    checkOutput("b2b_req2", 32'(mem_if.mem_req), 32'd1);
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt    = 1'b0;
    pulse_count += int'(req_if.rsp_valid);
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'h9ABC_1234;
    tick();
    mem_if.mem_rvalid = 1'b0;
    pulse_count += int'(req_if.rsp_valid);
    checkOutput("b2b_rdata2", req_if.rsp_rdata, 32'h0000_9ABC);
    for (int i = 0; i < 3; i++) begin
      tick();
      pulse_count += int'(req_if.rsp_valid);
    end
    checkOutput("b2b_pulses", 32'(pulse_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
